// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS data-memory responder.
//   state_t  : responder FSM encoding (S_IDLE, S_WAIT, S_RESP)
//   WORD_W   : data word width
//   BE_W     : byte-enable width
//   be_merge : replaces the byte lanes of old_w selected by be with those of new_w
package mips_mem_pkg;

   localparam int WORD_W = 32;
   localparam int BE_W   = 4;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   function automatic logic [WORD_W-1:0] be_merge(input logic [WORD_W-1:0] old_w,
                                                  input logic [WORD_W-1:0] new_w,
                                                  input logic [BE_W-1:0]   be);
      logic [WORD_W-1:0] r;
      r = old_w;
      for (int i = 0; i < BE_W; i++) begin
         if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/mips_data_mem_responder_if.sv
// Load/store port between the MIPS core (master) and the data memory (slave).
//   req_valid/req_ready : request handshake
//   req_we, req_be      : store flag and byte lanes
//   req_addr, req_wdata : byte address and store data
//   resp_valid/resp_ready : response handshake
//   resp_rdata, resp_err  : load data and error flag
interface mips_data_mem_responder_if;
   import mips_mem_pkg::*;

   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [BE_W-1:0]   req_be;
   logic [WORD_W-1:0] req_addr;
   logic [WORD_W-1:0] req_wdata;
   logic              resp_valid;
   logic              resp_ready;
   logic [WORD_W-1:0] resp_rdata;
   logic              resp_err;

   modport master (
      output req_valid, req_we, req_be, req_addr, req_wdata, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_we, req_be, req_addr, req_wdata, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err
   );

endinterface

// File: rtl/mips_be_ram.sv
// Byte-enabled single-port RAM, 2**DEPTH_LOG2 words of 32 bits.
// Synchronous write and synchronous read; a read in the same cycle as a write
// to the same word returns the old contents. Contents are never reset.
//   clk   : clock
//   we    : write enable
//   be    : byte lanes to write
//   addr  : word index
//   wdata : write data
//   rdata : registered read data
module mips_be_ram
   import mips_mem_pkg::*;
#(
   parameter int DEPTH_LOG2 = 8
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [BE_W-1:0]       be,
   input  logic [DEPTH_LOG2-1:0] addr,
   input  logic [WORD_W-1:0]     wdata,
   output logic [WORD_W-1:0]     rdata
);

   logic [WORD_W-1:0] mem_q [2**DEPTH_LOG2];

   always_ff @(posedge clk) begin
      if (we) mem_q[addr] <= be_merge(mem_q[addr], wdata, be);
      rdata <= mem_q[addr];
   end

endmodule

// File: rtl/mips_data_mem_responder.sv
// Memory-side responder for the MIPS load/store port. Accepts one request at a
// time, waits WAIT_CYCLES cycles, performs a byte-enabled store or a word load
// on the internal RAM, and holds the response until the core takes it.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : slave side of the load/store interface
//
//   state  | meaning
//   S_IDLE | req_ready high, waiting for a request
//   S_WAIT | request latched, wait counter running down to its terminal count
//   S_RESP | RAM accessed; response captured next cycle and held until taken
//
// The RAM access happens on the edge entering S_RESP (for WAIT_CYCLES==0 this
// is the accept edge itself, using the bus inputs directly). The registered RAM
// output is folded into the response one edge later, which gives the
// accept-to-valid latency of WAIT_CYCLES+1 edges.
module mips_data_mem_responder
   import mips_mem_pkg::*;
#(
   parameter int          DEPTH_LOG2  = 8,
   parameter int          WAIT_CYCLES = 2,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input logic                        clk,
   input logic                        rst,
   mips_data_mem_responder_if.slave   bus
);

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              we_q;
   logic [BE_W-1:0]   be_q;
   logic [WORD_W-1:0] addr_q;
   logic [WORD_W-1:0] wdata_q;
   logic              err_q;
   logic              cap_q;
   logic              resp_valid_q;
   logic [WORD_W-1:0] resp_rdata_q;
   logic              resp_err_q;

   logic              access;
   logic              cur_we;
   logic [BE_W-1:0]   cur_be;
   logic [WORD_W-1:0] cur_addr;
   logic [WORD_W-1:0] cur_wdata;
   logic [29:0]       cur_off_w;
   logic              cur_err;
   logic [WORD_W-1:0] ram_rdata;

   // In IDLE the access (zero-wait case) must use the live bus request.
   always_comb begin
      cur_we    = we_q;
      cur_be    = be_q;
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
      if (state_q == S_IDLE) begin
         cur_we    = bus.req_we;
         cur_be    = bus.req_be;
         cur_addr  = bus.req_addr;
         cur_wdata = bus.req_wdata;
      end
   end

   // Word offset from BASE_ADDR; addresses below the base wrap to huge offsets
   // and so fail the range check.
   assign cur_off_w = 30'((cur_addr - BASE_ADDR) >> 2);
   assign cur_err   = (cur_addr[1:0] != 2'b00) ||
                      (cur_off_w[29:DEPTH_LOG2] != '0);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      access  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.req_valid) begin
               if (WAIT_CYCLES == 0) begin
                  access  = 1'b1;
                  state_d = S_RESP;
               end else begin
                  cnt_d   = 4'(WAIT_CYCLES - 1);
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd0) begin
               access  = 1'b1;
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_RESP: begin
            if (resp_valid_q && bus.resp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         cnt_q        <= 4'd0;
         we_q         <= 1'b0;
         be_q         <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         err_q        <= 1'b0;
         cap_q        <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cap_q   <= access;
         if (state_q == S_IDLE && bus.req_valid) begin
            we_q    <= bus.req_we;
            be_q    <= bus.req_be;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
         end
         if (access) err_q <= cur_err;
         if (cap_q) begin
            resp_valid_q <= 1'b1;
            resp_err_q   <= err_q;
            resp_rdata_q <= (we_q || err_q) ? '0 : ram_rdata;
         end else if (resp_valid_q && bus.resp_ready) begin
            resp_valid_q <= 1'b0;
         end
      end
   end

   mips_be_ram #(
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_ram (
      .clk   (clk),
      .we    (access && cur_we && !cur_err),
      .be    (cur_be),
      .addr  (cur_off_w[DEPTH_LOG2-1:0]),
      .wdata (cur_wdata),
      .rdata (ram_rdata)
   );

   assign bus.req_ready  = (state_q == S_IDLE);
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_rdata = resp_rdata_q;
   assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_mips_data_mem_responder.sv
module tb_mips_data_mem_responder;
   import mips_mem_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   mips_data_mem_responder_if b0 ();
   mips_data_mem_responder_if b1 ();
   mips_data_mem_responder_if b2 ();

   mips_data_mem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(2), .BASE_ADDR(32'h0))
      dut0 (.clk(clk), .rst(rst), .bus(b0));
   mips_data_mem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(0), .BASE_ADDR(32'h0))
      dut1 (.clk(clk), .rst(rst), .bus(b1));
   mips_data_mem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(2), .BASE_ADDR(32'h100))
      dut2 (.clk(clk), .rst(rst), .bus(b2));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int sel, input logic v, input logic we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wd, input logic rr);
      case (sel)
         0: begin b0.req_valid = v; b0.req_we = we; b0.req_be = be;
                  b0.req_addr = addr; b0.req_wdata = wd; b0.resp_ready = rr; end
         1: begin b1.req_valid = v; b1.req_we = we; b1.req_be = be;
                  b1.req_addr = addr; b1.req_wdata = wd; b1.resp_ready = rr; end
         default: begin b2.req_valid = v; b2.req_we = we; b2.req_be = be;
                  b2.req_addr = addr; b2.req_wdata = wd; b2.resp_ready = rr; end
      endcase
   endtask

   function automatic logic get_ready(input int sel);
      case (sel)
         0: return b0.req_ready;
         1: return b1.req_ready;
         default: return b2.req_ready;
      endcase
   endfunction

   function automatic logic get_valid(input int sel);
      case (sel)
         0: return b0.resp_valid;
         1: return b1.resp_valid;
         default: return b2.resp_valid;
      endcase
   endfunction

   function automatic logic [31:0] get_rdata(input int sel);
      case (sel)
         0: return b0.resp_rdata;
         1: return b1.resp_rdata;
         default: return b2.resp_rdata;
      endcase
   endfunction

   function automatic logic get_err(input int sel);
      case (sel)
         0: return b0.resp_err;
         1: return b1.resp_err;
         default: return b2.resp_err;
      endcase
   endfunction

   // One complete transaction with resp_ready held high; returns response and
   // the number of edges from the accept edge to the first resp_valid.
   task automatic txn(input int sel, input logic we, input logic [3:0] be,
                      input logic [31:0] addr, input logic [31:0] wd,
                      output logic [31:0] rdata, output logic err, output int lat);
      int k;
      @(negedge clk);
      drive(sel, 1'b1, we, be, addr, wd, 1'b1);
      k = 0;
      while (get_ready(sel) !== 1'b1 && k < 50) begin
         @(negedge clk);
         k++;
      end
      if (k >= 50) chk("accept_timeout", 32'(get_ready(sel)), 32'd1);
      @(posedge clk); #1;
      drive(sel, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (get_valid(sel) !== 1'b1 && lat < 50);
      if (lat >= 50) chk("resp_timeout", 32'(get_valid(sel)), 32'd1);
      rdata = get_rdata(sel);
      err   = get_err(sel);
      @(posedge clk); #1;
   endtask

   initial begin
      logic [31:0] rd;
      logic        er;
      int          lat;
      int          k;

      drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
      drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
      drive(2, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_req_ready",  32'(b0.req_ready),  32'd1);
      chk("rst_resp_valid", 32'(b0.resp_valid), 32'd0);
      chk("rst_resp_rdata", b0.resp_rdata,      32'h0);
      chk("rst_resp_err",   32'(b0.resp_err),   32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("idle_req_ready",  32'(b0.req_ready),  32'd1);
      chk("idle_resp_valid", 32'(b0.resp_valid), 32'd0);

      // Store then load
      txn(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, rd, er, lat);
      chk("st10_lat", 32'(lat), 32'd3);
      chk("st10_rdata", rd, 32'h0);
      chk("st10_err", 32'(er), 32'd0);
      txn(0, 1'b0, 4'h0, 32'h10, 32'h0, rd, er, lat);
      chk("ld10_lat", 32'(lat), 32'd3);
      chk("ld10_rdata", rd, 32'hDEADBEEF);
      chk("ld10_err", 32'(er), 32'd0);

      // Byte lanes and zero byte-enable no-op
      txn(0, 1'b1, 4'hF, 32'h20, 32'h11223344, rd, er, lat);
      txn(0, 1'b1, 4'b0101, 32'h20, 32'hAABBCCDD, rd, er, lat);
      txn(0, 1'b0, 4'h0, 32'h20, 32'h0, rd, er, lat);
      chk("lanes_rdata", rd, 32'h11BB33DD);
      txn(0, 1'b1, 4'h0, 32'h20, 32'hFFFFFFFF, rd, er, lat);
      chk("be0_err", 32'(er), 32'd0);
      chk("be0_rdata", rd, 32'h0);
      txn(0, 1'b0, 4'hA, 32'h20, 32'h0, rd, er, lat);
      chk("be0_unchanged", rd, 32'h11BB33DD);

      // Errors
      txn(0, 1'b0, 4'hF, 32'h13, 32'h0, rd, er, lat);
      chk("mis_err", 32'(er), 32'd1);
      chk("mis_rdata", rd, 32'h0);
      txn(0, 1'b1, 4'hF, 32'h0, 32'hCAFEF00D, rd, er, lat);
      txn(0, 1'b1, 4'hF, 32'h400, 32'h01234567, rd, er, lat);
      chk("oor_st_err", 32'(er), 32'd1);
      txn(0, 1'b0, 4'h0, 32'h0, 32'h0, rd, er, lat);
      chk("oor_no_alias", rd, 32'hCAFEF00D);
      chk("w0_err", 32'(er), 32'd0);
      txn(0, 1'b0, 4'h0, 32'h3FC, 32'h0, rd, er, lat);
      chk("last_word_err", 32'(er), 32'd0);

      // Non-zero base address
      txn(2, 1'b0, 4'h0, 32'hFC, 32'h0, rd, er, lat);
      chk("base_below_err", 32'(er), 32'd1);
      chk("base_below_rdata", rd, 32'h0);
      txn(2, 1'b1, 4'hF, 32'h100, 32'h0BADC0DE, rd, er, lat);
      chk("base_st_err", 32'(er), 32'd0);
      txn(2, 1'b0, 4'h0, 32'h100, 32'h0, rd, er, lat);
      chk("base_ld_rdata", rd, 32'h0BADC0DE);
      txn(2, 1'b0, 4'h0, 32'h500, 32'h0, rd, er, lat);
      chk("base_top_err", 32'(er), 32'd1);

      // Backpressure: load held in RESP, second request waiting on the bus
      @(negedge clk);
      drive(0, 1'b1, 1'b0, 4'h0, 32'h10, 32'h0, 1'b0);
      @(posedge clk); #1;
      chk("bp_busy_ready", 32'(b0.req_ready), 32'd0);
      drive(0, 1'b1, 1'b1, 4'hF, 32'h40, 32'h00000055, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      chk("bp_valid", 32'(b0.resp_valid), 32'd1);
      chk("bp_rdata", b0.resp_rdata, 32'hDEADBEEF);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("bp_hold_valid", 32'(b0.resp_valid), 32'd1);
         chk("bp_hold_rdata", b0.resp_rdata, 32'hDEADBEEF);
         chk("bp_hold_err", 32'(b0.resp_err), 32'd0);
         chk("bp_hold_ready", 32'(b0.req_ready), 32'd0);
      end
      @(negedge clk);
      b0.resp_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_hs_valid", 32'(b0.resp_valid), 32'd0);
      chk("bp_hs_ready", 32'(b0.req_ready), 32'd1);
      @(posedge clk); #1;
      chk("bp_second_accepted", 32'(b0.req_ready), 32'd0);
      b0.req_valid = 1'b0;
      k = 0;
      do begin
         @(posedge clk); #1;
         k++;
      end while (b0.resp_valid !== 1'b1 && k < 50);
      chk("bp_second_lat", 32'(k), 32'd3);
      chk("bp_second_rdata", b0.resp_rdata, 32'h0);
      @(posedge clk); #1;
      txn(0, 1'b0, 4'h0, 32'h40, 32'h0, rd, er, lat);
      chk("bp_second_written", rd, 32'h00000055);

      // Reset while a store sits in WAIT
      txn(0, 1'b1, 4'hF, 32'h30, 32'h12345678, rd, er, lat);
      @(negedge clk);
      drive(0, 1'b1, 1'b1, 4'hF, 32'h30, 32'hFFFFFFFF, 1'b1);
      @(posedge clk); #1;
      drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
      chk("rw_in_wait", 32'(b0.req_ready), 32'd0);
      #1 rst = 1'b1;
      #1;
      chk("rw_async_ready", 32'(b0.req_ready), 32'd1);
      chk("rw_async_valid", 32'(b0.resp_valid), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      txn(0, 1'b0, 4'h0, 32'h30, 32'h0, rd, er, lat);
      chk("rw_old_value", rd, 32'h12345678);

      // Zero wait states
      txn(1, 1'b1, 4'hF, 32'h8, 32'hA5A5A5A5, rd, er, lat);
      chk("w0_st_lat", 32'(lat), 32'd1);
      txn(1, 1'b0, 4'h0, 32'h8, 32'h0, rd, er, lat);
      chk("w0_ld_lat", 32'(lat), 32'd1);
      chk("w0_ld_rdata", rd, 32'hA5A5A5A5);
      txn(1, 1'b0, 4'h0, 32'h402, 32'h0, rd, er, lat);
      chk("w0_mis_err", 32'(er), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
